fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'hbfc0_0380, the general exception entry address.
REQ-002 SHALL have parameter ERET_CODE, default 32'h0000_000e, the excepttype value that denotes eret.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port stallreq_if  input  1  instruction fetch not complete.
REQ-006 SHALL have port stallreq_id  input  1  decode needs a hold (load-use).
REQ-007 SHALL have port stallreq_ex  input  1  execute needs a hold (multi-cycle op).
REQ-008 SHALL have port stallreq_mem  input  1  data access not complete.
REQ-009 SHALL have port excepttype_i  input  32  exception code from MEM; zero means none.
REQ-010 SHALL have port cp0_epc_i  input  32  EPC value for eret.
REQ-011 SHALL have port branch_e  input  1  taken branch/jump resolved in ID.
REQ-012 SHALL have port branch_target_addr  input  32  target of that branch.
REQ-013 SHALL have port stall  output  6  stall bus, bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
REQ-014 SHALL have port flush  output  1  squash all stages and load new_pc.
REQ-015 SHALL have port new_pc  output  32  redirect address when flush is 1.
REQ-016 SHALL have port branch_e_o  output  1  branch redirect to the PC register.
REQ-017 SHALL have port branch_target_o  output  32  branch redirect address.

Function
REQ-018 SHALL compute the stall bus combinationally, priority mem>ex>id>if: 6'b011111, 6'b001111, 6'b000111, 6'b000011; none -> 6'b000000.
REQ-019 SHALL force stall to 6'b000000 whenever flush is 1.
REQ-020 SHALL implement states IDLE, BR_PEND, FL_PEND in a registered state variable.
REQ-021 IDLE: excepttype_i!=0 -> flush=1 same cycle; new_pc=cp0_epc_i if excepttype_i==ERET_CODE, else EXC_VECTOR.
REQ-022 IDLE: exception while stallreq_if=1 -> latch new_pc, next state FL_PEND.
REQ-023 FL_PEND: flush=1, new_pc=latched value, stall=0; exit to IDLE on first cycle stallreq_if=0, flush still 1 that cycle.
REQ-024 FL_PEND: new nonzero excepttype_i -> overwrite latched new_pc (REQ-021 rules), remain FL_PEND.
REQ-025 IDLE, no exception: branch_e=1 and stall[0]=0 -> branch_e_o=1, branch_target_o=branch_target_addr same cycle, no state change.
REQ-026 IDLE, no exception: branch_e=1 and stall[0]=1 -> latch target, next state BR_PEND; branch_e_o=0 that cycle.
REQ-027 BR_PEND: branch_e_o=1, branch_target_o=latched target; return to IDLE after first cycle with stall[0]=0.
REQ-028 BR_PEND: branch_e=1 again -> overwrite latched target.
REQ-029 Exception in BR_PEND -> discard pending branch, branch_e_o=0, apply REQ-021/022 (FL_PEND or IDLE).
REQ-030 Flush outranks branch: flush=1 -> branch_e_o=0 in any state.
REQ-031 Outside the cases above, branch_e_o=0 and branch_target_o=32'h0.
REQ-032 new_pc SHALL be 32'h0 when flush is 0.

Reset
REQ-033 rst=1 at a clock edge -> state IDLE, latched new_pc and branch target cleared to 0, from any state including mid FL_PEND/BR_PEND.
REQ-034 During rst=1: flush=0, branch_e_o=0, stall=6'b000000, new_pc=0, branch_target_o=0 regardless of inputs.

Verification
REQ-035 stallreq_ex=1, stallreq_if=1 -> stall=6'b001111; add stallreq_mem=1 -> 6'b011111.
REQ-036 excepttype_i=32'h1, stallreq_if=0 -> flush=1, new_pc=32'hbfc0_0380 one cycle; next cycle flush=0.
REQ-037 excepttype_i=32'he, cp0_epc_i=32'hbfc0_1234, stallreq_if=1 for 3 cycles -> flush=1, new_pc=32'hbfc0_1234 for 4 cycles, then 0.
REQ-038 branch_e=1, target 32'hbfc0_0100, stallreq_mem=1 for 2 cycles -> branch_e_o=1 with that target in cycles 2-3, 0 afterward.
REQ-039 In BR_PEND, excepttype_i=32'h1 -> branch_e_o=0, flush=1, new_pc=32'hbfc0_0380, state IDLE.
REQ-040 rst=1 mid-FL_PEND -> next cycle flush=0, new_pc=0, stall=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch-side pipeline control: stall bus generation, exception/eret flush
// redirect and branch redirect, holding either redirect until fetch can accept it.
module fetch_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hbfc0_0380,
    parameter logic [31:0] ERET_CODE  = 32'h0000_000e
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        branch_e,
    input  logic [31:0] branch_target_addr,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        branch_e_o,
    output logic [31:0] branch_target_o
);

    typedef enum logic [1:0] {IDLE, BR_PEND, FL_PEND} state_t;

    state_t      state_q, state_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] bt_q, bt_d;

    logic [5:0]  stall_raw;
    logic        exc;
    logic [31:0] exc_pc;
    logic        flush_c;
    logic [31:0] newpc_c;
    logic        br_c;
    logic [31:0] bt_c;

    always_comb begin
        if (stallreq_mem)      stall_raw = 6'b011111;
        else if (stallreq_ex)  stall_raw = 6'b001111;
        else if (stallreq_id)  stall_raw = 6'b000111;
        else if (stallreq_if)  stall_raw = 6'b000011;
        else                   stall_raw = 6'b000000;
    end

    assign exc    = (excepttype_i != 32'h0);
    assign exc_pc = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;

    always_comb begin
        state_d = state_q;
        npc_d   = npc_q;
        bt_d    = bt_q;
        flush_c = 1'b0;
        newpc_c = 32'h0;
        br_c    = 1'b0;
        bt_c    = 32'h0;
        case (state_q)
            IDLE, BR_PEND: begin
                if (exc) begin
                    // An exception squashes any pending branch; hold the
                    // redirect if fetch cannot take it this cycle.
                    flush_c = 1'b1;
                    newpc_c = exc_pc;
                    bt_d    = 32'h0;
                    if (stallreq_if) begin
                        npc_d   = exc_pc;
                        state_d = FL_PEND;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (state_q == BR_PEND) begin
                    br_c = 1'b1;
                    bt_c = branch_e ? branch_target_addr : bt_q;
                    if (branch_e) bt_d = branch_target_addr;
                    if (!stall_raw[0]) state_d = IDLE;
                end else if (branch_e) begin
                    if (!stall_raw[0]) begin
                        br_c = 1'b1;
                        bt_c = branch_target_addr;
                    end else begin
                        bt_d    = branch_target_addr;
                        state_d = BR_PEND;
                    end
                end
            end
            FL_PEND: begin
                flush_c = 1'b1;
                if (exc) begin
                    newpc_c = exc_pc;
                    npc_d   = exc_pc;
                end else begin
                    newpc_c = npc_q;
                end
                if (!stallreq_if) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall           = 6'b000000;
        flush           = 1'b0;
        new_pc          = 32'h0;
        branch_e_o      = 1'b0;
        branch_target_o = 32'h0;
        if (!rst) begin
            stall           = flush_c ? 6'b000000 : stall_raw;
            flush           = flush_c;
            new_pc          = newpc_c;
            branch_e_o      = br_c;
            branch_target_o = bt_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            npc_q   <= 32'h0;
            bt_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            npc_q   <= npc_d;
            bt_q    <= bt_d;
        end
    end

endmodule
